// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter: writeback packet type and the producer/CDB
// interface bundle. The packet type lives in a package so that the
// interface, the arbiter and the bench all share one definition.
package cdb_arbiter_pkg;
  localparam int TAG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  is_valid;
    logic                  is_exception;
    logic [TAG_WIDTH-1:0]  dest_tag;
    logic [DATA_WIDTH-1:0] result;
  } writeback_packet_t;
endpackage

interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2
);
  import cdb_arbiter_pkg::*;

  logic              flush_i;
  writeback_packet_t req_pkt_i [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready_o;
  writeback_packet_t cdb_o [NUM_CDB];
  logic [NUM_REQ-1:0] grant_o;

  // Producer / pipeline-control side.
  modport master (
    output flush_i,
    output req_pkt_i,
    input  req_ready_o,
    input  cdb_o,
    input  grant_o
  );

  // Arbiter side.
  modport slave (
    input  flush_i,
    input  req_pkt_i,
    output req_ready_o,
    output cdb_o,
    output grant_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each result producer owns a one-entry holding
// register; every cycle a round-robin scan starting at rr_ptr grants up to
// NUM_CDB occupied registers onto the CDB slots, filling slot 0 upward.
// All outputs are decoded purely from flops, so the bus carries no
// combinational path from the producers' request inputs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] hold_valid;
  writeback_packet_t  hold_pkt [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] accept;
  writeback_packet_t  slot [NUM_CDB];

  // Scan temporaries for the arbitration loop.
  int               grant_cnt;
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W-1:0] last_idx;

  // Round-robin scan: the first NUM_CDB occupied registers from rr_ptr win,
  // and the k-th winner lands in slot k so the slots never have gaps.
  always_comb begin
    grant     = '0;
    grant_cnt = 0;
    scan_idx  = '0;
    last_idx  = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      slot[s] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (hold_valid[scan_idx] && (grant_cnt < NUM_CDB)) begin
        grant[scan_idx] = 1'b1;
        last_idx        = scan_idx;
        for (int s = 0; s < NUM_CDB; s++) begin
          if (s == grant_cnt) begin
            slot[s]          = hold_pkt[scan_idx];
            slot[s].is_valid = 1'b1;
          end else begin
            slot[s] = slot[s];
          end
        end
        grant_cnt = grant_cnt + 1;
      end else begin
        grant_cnt = grant_cnt;
      end
    end
    if (grant_cnt > 0) begin
      rr_ptr_next = PTR_W'((int'(last_idx) + 1) % NUM_REQ);
    end else begin
      rr_ptr_next = rr_ptr;
    end
  end

  // A register frees up either when empty or when it is draining this cycle,
  // which lets a producer granted every cycle refill with no bubble.
  always_comb begin
    ready  = '0;
    accept = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i]  = ~hold_valid[i] | grant[i];
      accept[i] = bus.req_pkt_i[i].is_valid & ready[i];
    end
  end

  // Drive the interface outputs from the flop-derived decode.
  always_comb begin
    bus.req_ready_o = ready;
    bus.grant_o     = grant;
    for (int s = 0; s < NUM_CDB; s++) begin
      bus.cdb_o[s] = slot[s];
    end
  end

  // Holding registers and round-robin pointer. Flush beats accept but leaves
  // the pointer to advance on the grants that were still broadcast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_pkt[i] <= '0;
      end
    end else begin
      rr_ptr <= rr_ptr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.flush_i) begin
          hold_valid[i] <= 1'b0;
        end else if (accept[i]) begin
          hold_valid[i] <= 1'b1;
          hold_pkt[i]   <= bus.req_pkt_i[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end else begin
          hold_valid[i] <= hold_valid[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NC = 2;

  logic clk;
  logic rst_n;

  cdb_arbiter_if #(.NUM_REQ(NR), .NUM_CDB(NC)) bus ();

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which producers hold a packet, what it is, and where
  // the next round-robin scan starts.
  bit                m_valid [NR];
  writeback_packet_t m_pkt   [NR];
  int                m_ptr;

  writeback_packet_t stim [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_pkt[i]   = '0;
    end
    m_ptr = 0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NR; i++) stim[i] = '0;
  endtask

  function automatic writeback_packet_t mk_pkt(input int tag, input logic [31:0] res);
    writeback_packet_t p;
    p.is_valid     = 1'b1;
    p.is_exception = 1'b0;
    p.dest_tag     = TAG_WIDTH'(tag);
    p.result       = res;
    return p;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cdb0"},  64'(bus.cdb_o[0]), 64'd0);
    check({tag, "_cdb1"},  64'(bus.cdb_o[1]), 64'd0);
    check({tag, "_grant"}, 64'(bus.grant_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.req_ready_o), 64'hF);
  endtask

  // One clock cycle: drive stim/flush, compare outputs with the model, then
  // advance the model to what the coming rising edge must produce.
  task automatic step(input bit fl);
    int                q[$];
    bit [NR-1:0]       eg;
    bit [NR-1:0]       er;
    writeback_packet_t es [NC];
    int                ng;
    @(negedge clk);
    bus.flush_i = fl;
    for (int i = 0; i < NR; i++) bus.req_pkt_i[i] = stim[i];
    #1;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (m_valid[j]) q.push_back(j);
    end
    ng = (q.size() < NC) ? q.size() : NC;
    eg = '0;
    for (int s = 0; s < NC; s++) begin
      es[s] = '0;
      if (s < ng) begin
        es[s]          = m_pkt[q[s]];
        es[s].is_valid = 1'b1;
        eg[q[s]]       = 1'b1;
      end
    end
    for (int i = 0; i < NR; i++) er[i] = !m_valid[i] || eg[i];
    check("cdb0",  64'(bus.cdb_o[0]), 64'(es[0]));
    check("cdb1",  64'(bus.cdb_o[1]), 64'(es[1]));
    check("grant", 64'(bus.grant_o), 64'(eg));
    check("ready", 64'(bus.req_ready_o), 64'(er));
    if (ng > 0) m_ptr = (q[ng-1] + 1) % NR;
    for (int i = 0; i < NR; i++) begin
      if (fl) m_valid[i] = 1'b0;
      else if (stim[i].is_valid && er[i]) begin
        m_valid[i] = 1'b1;
        m_pkt[i]   = stim[i];
      end else if (eg[i]) m_valid[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.flush_i = 1'b0;
    clear_stim();
    for (int i = 0; i < NR; i++) bus.req_pkt_i[i] = '0;
    model_reset();
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    step(1'b0);
    step(1'b0);

    // Single requester: req 2 with tag 5, result DEADBEEF.
    stim[2] = mk_pkt(5, 32'hDEADBEEF);
    step(1'b0);
    clear_stim();
    step(1'b0);
    check("single_grant",  64'(bus.grant_o), 64'h4);
    check("single_tag",    64'(bus.cdb_o[0].dest_tag), 64'd5);
    check("single_result", 64'(bus.cdb_o[0].result), 64'hDEADBEEF);
    check("single_slot1",  64'(bus.cdb_o[1].is_valid), 64'd0);

    // Wrap-around with rr_ptr at 3: holds on 0, 1, 3.
    stim[0] = mk_pkt(10, 32'h0000_0A00);
    stim[1] = mk_pkt(11, 32'h0000_0B11);
    stim[3] = mk_pkt(13, 32'h0000_0D33);
    step(1'b0);
    clear_stim();
    step(1'b0);
    check("wrap_grant", 64'(bus.grant_o), 64'h9);
    check("wrap_ready", 64'(bus.req_ready_o), 64'hD);
    check("wrap_slot0", 64'(bus.cdb_o[0].dest_tag), 64'd13);
    check("wrap_slot1", 64'(bus.cdb_o[1].dest_tag), 64'd10);
    step(1'b0);
    check("wrap_left", 64'(bus.grant_o), 64'h2);
    step(1'b0);

    // Oversubscription: every producer refills each cycle.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NR; i++) stim[i] = mk_pkt(16 + i + c, 32'(c * 256 + i));
      step(1'b0);
    end
    clear_stim();
    step(1'b0);
    step(1'b0);

    // Flush with holds on 1..3 and a same-cycle new packet on req 0.
    stim[1] = mk_pkt(1, 32'h1111_1111);
    stim[2] = mk_pkt(2, 32'h2222_2222);
    stim[3] = mk_pkt(3, 32'h3333_3333);
    step(1'b0);
    clear_stim();
    stim[0] = mk_pkt(7, 32'h7777_7777);
    step(1'b1);
    clear_stim();
    step(1'b0);
    check("flush_grant", 64'(bus.grant_o), 64'd0);
    check("flush_cdb0",  64'(bus.cdb_o[0].is_valid), 64'd0);
    step(1'b0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        stim[i].is_valid     = ($urandom_range(0, 2) != 0);
        stim[i].is_exception = 1'($urandom_range(0, 1));
        stim[i].dest_tag     = TAG_WIDTH'($urandom);
        stim[i].result       = $urandom;
      end
      step($urandom_range(0, 15) == 0);
    end

    // Asynchronous reset between edges with all holds full.
    bus.flush_i = 1'b0;
    for (int i = 0; i < NR; i++) stim[i] = mk_pkt(24 + i, 32'hCAFE_0000 + 32'(i));
    step(1'b0);
    clear_stim();
    step(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the `PIPE_WIDTH` common data bus (CDB) write ports among the execution-unit result producers (ALU lanes, MDU, LSU).
- Each requester hands a `writeback_packet_t` to a one-entry holding register.
- Each cycle a round-robin scheduler grants up to `NUM_CDB` held packets onto the CDB slots, which feed ROB, reservation stations and LSQ wakeup.
- `flush_i` (branch mispredict / exception redirect) discards all held results.

Parameters:
- `NUM_REQ`, 4, number of result producers (index 0..NUM_REQ-1).
- `NUM_CDB`, 2 (=`PIPE_WIDTH`), number of CDB broadcast slots per cycle; 1 <= NUM_CDB <= NUM_REQ.
- `TAG_WIDTH`, 5 (=`$clog2(ROB_ENTRIES)`), ROB tag width carried in `dest_tag`.

Ports:
- `clk`  input  1  core clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `flush_i`  input  1  pipeline flush; clears all holding registers.
- `req_pkt_i`  input  NUM_REQ x writeback_packet_t  producer results; `.is_valid` is the request.
- `req_ready_o`  output  NUM_REQ  producer may hand over a packet this cycle.
- `cdb_o`  output  NUM_CDB x writeback_packet_t  broadcast packets; `.is_valid` marks an occupied slot.
- `grant_o`  output  NUM_REQ  one-hot-per-requester mask of holding registers broadcast this cycle.

Behaviour:
- State:
  - per requester `hold_valid[i]` and `hold_pkt[i]`;
  - `rr_ptr` of $clog2(NUM_REQ) bits.
- Reset (async, `rst_n`=0):
  - `hold_valid` all 0, `hold_pkt` all 0, `rr_ptr`=0.
  - Therefore `cdb_o[*]` is all-zero with `is_valid`=0, `grant_o`=0, `req_ready_o`=all 1.
- Arbitration (combinational from flops only):
  - Scan indices `rr_ptr`, `rr_ptr+1`, ... mod NUM_REQ.
  - The first NUM_CDB indices with `hold_valid`=1 are granted, in scan order.
  - The k-th granted index drives `cdb_o[k]` = its `hold_pkt` with `is_valid`=1.
  - Ungranted slots output all-zero.
- `grant_o[i]`=1 iff holding register i drives some slot this cycle. This holds even when `flush_i`=1; downstream consumers gate CDB with flush themselves.
- Round-robin update:
  - If any grant, `rr_ptr` <= (last granted index + 1) mod NUM_REQ.
  - If no grant, `rr_ptr` is unchanged.
  - `flush_i` does not alter `rr_ptr`.
- Handshake:
  - `req_ready_o[i]` = ~`hold_valid[i]` | `grant_o[i]`; it has no dependence on `req_pkt_i`.
  - Accept when `req_pkt_i[i].is_valid` & `req_ready_o[i]`: `hold_pkt[i]` <= `req_pkt_i[i]`, `hold_valid[i]` <= 1.
  - Held & granted & no new accept: `hold_valid[i]` <= 0.
  - Held & not granted: register is unchanged; the producer must stall and hold its packet.
- Latency:
  - A packet accepted at edge N is broadcast no earlier than cycle N+1.
  - Minimum one cycle accept-to-CDB.
  - With `hold_valid` full on every requester, each requester is granted at least once every ceil(NUM_REQ/NUM_CDB) cycles (no starvation).
- Throughput: a requester granted every cycle can accept every cycle, i.e. back-to-back with no bubble.
- `flush_i`=1 at edge: all `hold_valid` <= 0 and accepts in that cycle are discarded. Flush has priority over accept. CDB outputs in the flush cycle still reflect pre-flush holding state.
- `is_exception`, `dest_tag` and `result` pass through bit-exact. The arbiter never inspects tags, so duplicate tags are not checked.
- Fewer than NUM_CDB occupied entries: the remaining upper slots are invalid. Slots are always filled from slot 0 upward, with no gaps.
- Reset asserted mid-operation: held packets are lost and outputs return immediately (asynchronously) to reset values.

Test Plan:
1. Reset, then idle:
   - `rst_n` low then high, no requests.
   - `cdb_o[0..1].is_valid`=0, `grant_o`=0000, `req_ready_o`=1111, `rr_ptr`=0.
2. Single requester:
   - Req 2 sends tag 5, result 0xDEADBEEF at cycle 1.
   - Cycle 2: `cdb_o[0]`={5, 0xDEADBEEF, valid}, `cdb_o[1]` invalid, `grant_o`=0100; next `rr_ptr`=3.
3. Oversubscription:
   - All 4 requesters held from cycle 1, `rr_ptr`=0, producers refill every cycle.
   - Cycle 1 grants {0,1}; cycle 2 grants {2,3}; cycle 3 grants {0,1}.
   - `req_ready_o` is 1 only for granted indices.
4. Wrap-around:
   - `rr_ptr`=3, holds valid on 0, 1, 3.
   - `cdb_o[0]`=req3, `cdb_o[1]`=req0; req1 is not granted, stays held, `req_ready_o[1]`=0; next `rr_ptr`=1.
5. Flush:
   - Holds valid on 1, 2, 3; same cycle, req0 presents a new packet and `flush_i`=1.
   - Next cycle: all `hold_valid`=0, no CDB valid, req0 packet dropped, `rr_ptr` advanced per the pre-flush grants.
6. Async reset mid-stream:
   - Drop `rst_n` between clock edges while holds are full.
   - `cdb_o` invalid and `req_ready_o`=1111 before the next edge.
   - After release, no stale packet is broadcast.
